// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//
// Tracks the instructions that have left ID in a small shadow pipeline and
// uses it to decide, in the same cycle, whether the ID instruction must
// stall, whether IF/ID must be flushed and where each source operand should
// be forwarded from.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_src1/2    ID source register addresses (src2 only read when id_use_src2)
//   id_use_src2  ID instruction reads id_src2
//   id_wb_en     ID instruction writes a register
//   id_mem_read  ID instruction is a load
//   id_dest      ID destination register
//   br_taken     branch in slot 1 resolved taken
//   stall        hold PC and IF/ID, insert a bubble
//   flush        discard IF/ID and the ID instruction
//   fwd_sel1/2   0 = register file, k = forward from slot k
//   occ          bit k-1 set when slot k holds a valid instruction
//   hazard_cnt   saturating count of stall cycles
module hazard_scoreboard_unit #(
  parameter int  AW     = 5,
  parameter int  STAGES = 3,
  parameter int  FWD_EN = 1,
  localparam int FW     = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_src1,
  input  logic [AW-1:0]     id_src2,
  input  logic              id_use_src2,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic [AW-1:0]     id_dest,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [FW-1:0]     fwd_sel1,
  output logic [FW-1:0]     fwd_sel2,
  output logic [STAGES-1:0] occ,
  output logic [15:0]       hazard_cnt
);

  // Slots 1..STAGES-1 are the only ones that can create a hazard; the last
  // slot is already being written to the register file, so it only carries
  // its valid bit (for occ). Only slot 1 ever needs its load flag.
  localparam int NH = STAGES - 1;

  logic [STAGES-1:0]     slotValid_q, slotValid_d;
  logic [NH-1:0]         slotWbEn_q, slotWbEn_d;
  logic [NH-1:0][AW-1:0] slotDest_q, slotDest_d;
  logic                  slot1MemRd_q, slot1MemRd_d;
  logic [15:0]           hazardCnt_q, hazardCnt_d;

  logic [NH-1:0]         match1, match2;
  logic                  hazardRaw;
  logic                  loadId;

  // A slot matches a source when it will write a non-zero register equal to
  // that source; src2 only counts when the ID instruction really reads it.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < NH; k++) begin
      match1[k] = slotValid_q[k] & slotWbEn_q[k] & (slotDest_q[k] != '0) &
                  (slotDest_q[k] == id_src1);
      match2[k] = slotValid_q[k] & slotWbEn_q[k] & (slotDest_q[k] != '0) &
                  (slotDest_q[k] == id_src2) & id_use_src2;
    end
  end

  // With forwarding only a load in slot 1 is unresolvable (its data is not
  // ready yet); without forwarding every in-flight producer blocks ID.
  always_comb begin
    hazardRaw = 1'b0;
    if (FWD_EN != 0) begin
      hazardRaw = id_valid & slot1MemRd_q & (match1[0] | match2[0]);
    end else begin
      hazardRaw = id_valid & ((|match1) | (|match2));
    end
  end

  // A taken branch squashes the ID instruction, so it never needs to wait.
  assign flush = br_taken & rst;
  assign stall = hazardRaw & ~br_taken;

  // Youngest producer wins: scan from the oldest forwardable slot down so the
  // last assignment is the smallest matching slot. A load in slot 1 cannot
  // forward because its data arrives a cycle later.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (FWD_EN != 0) begin
      for (int k = NH - 1; k >= 0; k--) begin
        if (match1[k] && !(k == 0 && slot1MemRd_q)) begin
          fwd_sel1 = FW'(k + 1);
        end
        if (match2[k] && !(k == 0 && slot1MemRd_q)) begin
          fwd_sel2 = FW'(k + 1);
        end
      end
    end
  end

  // Shift the shadow pipeline by one slot. Fields of bubble slots are left
  // as whatever was shifted in because the valid bit gates every use.
  always_comb begin
    loadId       = id_valid & ~stall & ~flush;
    slotValid_d  = {slotValid_q[STAGES-2:0], loadId};
    slotWbEn_d   = slotWbEn_q;
    slotDest_d   = slotDest_q;
    slotWbEn_d[0] = id_wb_en;
    slotDest_d[0] = id_dest;
    for (int k = 1; k < NH; k++) begin
      slotWbEn_d[k] = slotWbEn_q[k-1];
      slotDest_d[k] = slotDest_q[k-1];
    end
    slot1MemRd_d = id_mem_read;
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    hazardCnt_d = hazardCnt_q;
    if (stall && (hazardCnt_q != 16'hFFFF)) begin
      hazardCnt_d = hazardCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotValid_q  <= '0;
      slotWbEn_q   <= '0;
      slotDest_q   <= '0;
      slot1MemRd_q <= 1'b0;
      hazardCnt_q  <= 16'd0;
    end else begin
      slotValid_q  <= slotValid_d;
      slotWbEn_q   <= slotWbEn_d;
      slotDest_q   <= slotDest_d;
      slot1MemRd_q <= slot1MemRd_d;
      hazardCnt_q  <= hazardCnt_d;
    end
  end

  assign occ        = slotValid_q;
  assign hazard_cnt = hazardCnt_q;

endmodule
